frog_position: RTL and testbench

FROG_POSITION -- requirements
Module: frog_position

---
 rtl/frogger_pkg.sv | 15 +
 rtl/frog_position.sv | 131 +++++++++++++
 tb/tb_frog_position.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared game definitions: FSM state encoding and default playfield geometry.
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    SCORED    = 2'd1,
    SQUASHED  = 2'd2,
    GAME_OVER = 2'd3
  } frog_state_t;

  localparam int DEFAULT_ROWS      = 16;
  localparam int DEFAULT_COLS      = 16;
  localparam int DEFAULT_START_COL = 7;

endpackage

// File: rtl/frog_position.sv
// Frog position, lives and score tracker: moves on single-cycle pulses, dies on hazard,
// scores on reaching row 0, and holds for a respawn delay after either event.
module frog_position
  import frogger_pkg::*;
#(
  parameter int ROWS           = DEFAULT_ROWS,
  parameter int COLS           = DEFAULT_COLS,
  parameter int START_COL      = DEFAULT_START_COL,
  parameter int RESPAWN_CYCLES = 50_000_000,
  parameter int LIVES          = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    up,
  input  logic                    down,
  input  logic                    left,
  input  logic                    right,
  input  logic                    hazard,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic [2:0]              lives,
  output logic [3:0]              score,
  output logic                    win,
  output logic                    dead,
  output logic                    game_over
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0]    COL_START = CW'(START_COL);
  localparam logic [2:0]       LIVES_INI = 3'(LIVES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RESPAWN_CYCLES - 1);

  frog_state_t      state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [2:0]       lives_q, lives_d;
  logic [3:0]       score_q, score_d;
  logic             win_q, win_d;
  logic             dead_q, dead_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_move;

  assign single_move = $onehot({up, down, left, right});

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lives_d = lives_q;
    score_d = score_q;
    win_d   = 1'b0;
    dead_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      PLAY: begin
        if (hazard) begin
          // Hazard wins over any simultaneous move; the last life ends the game.
          dead_d  = 1'b1;
          lives_d = lives_q - 3'd1;
          cnt_d   = '0;
          state_d = (lives_q == 3'd1) ? GAME_OVER : SQUASHED;
        end else if (single_move) begin
          if (up && row_q != '0) begin
            row_d = row_q - RW'(1);
            if (row_q == RW'(1)) begin
              win_d   = 1'b1;
              cnt_d   = '0;
              state_d = SCORED;
              if (score_q != 4'd15) score_d = score_q + 4'd1;
            end
          end
          if (down && row_q != ROW_LAST) row_d = row_q + RW'(1);
          if (left && col_q != '0)       col_d = col_q - CW'(1);
          if (right && col_q != COL_LAST) col_d = col_q + CW'(1);
        end
      end

      SCORED, SQUASHED: begin
        if (cnt_q == CNT_LAST) begin
          state_d = PLAY;
          row_d   = ROW_LAST;
          col_d   = COL_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAME_OVER: ;

      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PLAY;
      row_q   <= ROW_LAST;
      col_q   <= COL_START;
      lives_q <= LIVES_INI;
      score_q <= 4'd0;
      win_q   <= 1'b0;
      dead_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lives_q <= lives_d;
      score_q <= score_d;
      win_q   <= win_d;
      dead_q  <= dead_d;
      cnt_q   <= cnt_d;
    end
  end

  assign row       = row_q;
  assign col       = col_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign win       = win_q;
  assign dead      = dead_q;
  assign game_over = (state_q == GAME_OVER);

endmodule

// File: tb/tb_frog_position.sv
// Randomised and directed checks of frog_position against a game-rule reference model.
module tb_frog_position;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int SC   = 7;
  localparam int RESP = 4;
  localparam int NLIV = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hazard = 1'b0;
  logic [3:0] row, col, score;
  logic [2:0] lives;
  logic       win, dead, game_over;

  int total = 0;
  int bad   = 0;

  // Reference model: plain game quantities, hold expressed as cycles remaining.
  int m_row, m_col, m_lives, m_score, m_hold;
  bit m_win, m_dead, m_over;

  always #5 clk = ~clk;

  frog_position #(
    .ROWS(ROWS), .COLS(COLS), .START_COL(SC), .RESPAWN_CYCLES(RESP), .LIVES(NLIV)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .hazard(hazard), .row(row), .col(col), .lives(lives), .score(score),
    .win(win), .dead(dead), .game_over(game_over)
  );

  function automatic logic [17:0] obs();
    return {row, col, lives, score, win, dead, game_over};
  endfunction

  function automatic logic [17:0] exp_v();
    return {4'(m_row), 4'(m_col), 3'(m_lives), 4'(m_score), m_win, m_dead, m_over};
  endfunction

  task automatic model_reset();
    m_row = ROWS - 1; m_col = SC; m_lives = NLIV; m_score = 0;
    m_hold = 0; m_win = 0; m_dead = 0; m_over = 0;
  endtask

  task automatic model_step(input bit u, input bit d, input bit l, input bit r, input bit h);
    int nr, nc;
    m_win = 0; m_dead = 0;
    if (m_over) return;
    if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin m_row = ROWS - 1; m_col = SC; end
      return;
    end
    if (h) begin
      m_dead = 1; m_lives--;
      if (m_lives == 0) m_over = 1; else m_hold = RESP;
      return;
    end
    if (int'(u) + int'(d) + int'(l) + int'(r) != 1) return;
    nr = m_row - int'(u) + int'(d);
    nc = m_col - int'(l) + int'(r);
    if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) return;
    m_row = nr; m_col = nc;
    if (m_row == 0) begin
      m_win = 1; m_hold = RESP;
      if (m_score < 15) m_score++;
    end
  endtask

  // Drive one cycle of inputs; outputs are settled on return (#1 after the edge).
  task automatic step(input bit u, input bit d, input bit l, input bit r, input bit h);
    @(negedge clk);
    up = u; down = d; left = l; right = r; hazard = h;
    @(posedge clk);
    model_step(u, d, l, r, h);
    #1;
    up = 0; down = 0; left = 0; right = 0; hazard = 0;
    $display("step in=%b%b%b%b%b row=%0d col=%0d lives=%0d score=%0d win=%b dead=%b go=%b",
             u, d, l, r, h, row, col, lives, score, win, dead, game_over);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if (obs() !== exp_v()) begin
      bad++; $display("FAIL reset_state got=%h want=%h", obs(), exp_v());
    end
    total++;
    if (row !== 4'd15 || col !== 4'd7 || lives !== 3'd3 || score !== 4'd0 || game_over !== 1'b0) begin
      bad++; $display("FAIL reset_consts got row=%0d col=%0d lives=%0d score=%0d go=%b want 15 7 3 0 0",
                      row, col, lives, score, game_over);
    end
  endtask

  task automatic test_left_moves();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      total++;
      if (obs() !== exp_v()) begin
        bad++; $display("FAIL left_move[%0d] got=%h want=%h", i, obs(), exp_v());
      end
    end
  endtask

  task automatic test_edges();
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    total++;
    if (col !== 4'd0 || obs() !== exp_v()) begin
      bad++; $display("FAIL left_edge got col=%0d vec=%h want col=0 vec=%h", col, obs(), exp_v());
    end
    step(0, 1, 0, 0, 0);
    total++;
    if (row !== 4'd15 || obs() !== exp_v()) begin
      bad++; $display("FAIL bottom_edge got row=%0d vec=%h want row=15 vec=%h", row, obs(), exp_v());
    end
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    total++;
    if (obs() !== exp_v()) begin
      bad++; $display("FAIL dual_press got=%h want=%h", obs(), exp_v());
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
    total++;
    if (col !== 4'd15 || obs() !== exp_v()) begin
      bad++; $display("FAIL right_edge got col=%0d vec=%h want col=15 vec=%h", col, obs(), exp_v());
    end
  endtask

  task automatic test_goal();
    int wins = 0;
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 0, 0);
      if (win) wins++;
      total++;
      if (obs() !== exp_v()) begin
        bad++; $display("FAIL goal_climb[%0d] got=%h want=%h", i, obs(), exp_v());
      end
    end
    for (int i = 0; i < RESP; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)));
      if (win) wins++;
      total++;
      if (obs() !== exp_v()) begin
        bad++; $display("FAIL goal_hold[%0d] got=%h want=%h", i, obs(), exp_v());
      end
    end
    total++;
    if (wins != 1 || row !== 4'd15 || col !== 4'd7 || score !== 4'd1) begin
      bad++; $display("FAIL goal_respawn got wins=%0d row=%0d col=%0d score=%0d want 1 15 7 1",
                      wins, row, col, score);
    end
    step(0, 0, 1, 0, 0);
    total++;
    if (obs() !== exp_v()) begin
      bad++; $display("FAIL goal_play_again got=%h want=%h", obs(), exp_v());
    end
  endtask

  task automatic test_hazard();
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1);
      total++;
      if (dead !== 1'b1 || obs() !== exp_v()) begin
        bad++; $display("FAIL squash[%0d] got=%h want=%h", k, obs(), exp_v());
      end
      for (int i = 0; i < RESP + 1; i++) begin
        step(0, 0, bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)) & (i < RESP));
        total++;
        if (obs() !== exp_v()) begin
          bad++; $display("FAIL squash_hold[%0d.%0d] got=%h want=%h", k, i, obs(), exp_v());
        end
      end
    end
    total++;
    if (lives !== 3'd0 || game_over !== 1'b1) begin
      bad++; $display("FAIL game_over got lives=%0d go=%b want 0 1", lives, game_over);
    end
    for (int i = 0; i < 8; i++) begin
      step(bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)), 0, bit'($urandom_range(0, 1)));
      total++;
      if (obs() !== exp_v()) begin
        bad++; $display("FAIL over_frozen[%0d] got=%h want=%h", i, obs(), exp_v());
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    reset_dut();
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2;
    reset = 1;
    model_reset();
    #1;
    total++;
    if (obs() !== exp_v()) begin
      bad++; $display("FAIL async_reset got=%h want=%h", obs(), exp_v());
    end
    @(negedge clk);
    reset = 0;
    left = 1;
    @(posedge clk);
    model_step(0, 0, 1, 0, 0);
    #1;
    left = 0;
    total++;
    if (col !== 4'd6 || obs() !== exp_v()) begin
      bad++; $display("FAIL first_move got col=%0d vec=%h want col=6 vec=%h", col, obs(), exp_v());
    end
  endtask

  task automatic test_score_sat();
    int wins = 0;
    reset_dut();
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < 15 + RESP; i++) begin
        step(i < 15, 0, 0, 0, 0);
        if (win) wins++;
      end
      total++;
      if (obs() !== exp_v()) begin
        bad++; $display("FAIL goal_cycle[%0d] got=%h want=%h", g, obs(), exp_v());
      end
    end
    total++;
    if (score !== 4'd15 || wins != 16) begin
      bad++; $display("FAIL score_sat got score=%0d wins=%0d want 15 16", score, wins);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      int sel;
      bit u, d, l, r, h;
      if (m_over && $urandom_range(0, 7) == 0) reset_dut();
      sel = int'($urandom_range(0, 11));
      u = (sel <= 3) || (sel == 9);
      d = (sel == 4);
      l = (sel == 5) || (sel == 9);
      r = (sel == 6) || (sel == 7);
      h = ($urandom_range(0, 24) == 0);
      step(u, d, l, r, h);
      total++;
      if (obs() !== exp_v()) begin
        bad++; $display("FAIL random[%0d] got=%h want=%h", i, obs(), exp_v());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left_moves();
    test_edges();
    test_goal();
    test_hazard();
    test_reset_mid_hold();
    test_score_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
